// File: rtl/video_timing_gen.sv
// Raster timing generator: sync, data-enable, coordinates and line/frame strobes for the DVI encoders.
// Optional colour-bar source enabled by defining VTG_TEST_PATTERN_EN; without it r/g/b are tied to 0.
module video_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;
    logic          active;
    logic          h_sync_on;
    logic          v_sync_on;

    assign h_wrap    = (h_cnt == H_LAST);
    assign v_wrap    = (v_cnt == V_LAST);
    assign active    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    assign h_sync_on = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    assign v_sync_on = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

    // Raster position; v_cnt only moves on the last column so vsync spans whole lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Outputs register the decode of the pre-edge counters, lagging them by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            hsync       <= h_sync_on ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= v_sync_on ? VSYNC_POL : ~VSYNC_POL;
            de          <= active;
            x           <= h_cnt;
            y           <= v_cnt;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VTG_TEST_PATTERN_EN
    localparam int            BAR_W    = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
    localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);

    logic [CW-1:0] bar_cnt;
    logic [2:0]    bar_idx;
    logic [2:0]    bar_rgb;

    // Down-counter per bar; bar_idx saturates at 7 so remainder columns stay black.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bar_cnt <= BAR_LAST;
            bar_idx <= 3'd0;
        end else if (en) begin
            if (h_wrap) begin
                bar_cnt <= BAR_LAST;
                bar_idx <= 3'd0;
            end else if (bar_cnt == '0) begin
                bar_cnt <= BAR_LAST;
                if (bar_idx != 3'd7) begin
                    bar_idx <= bar_idx + 3'd1;
                end
            end else begin
                bar_cnt <= bar_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        bar_rgb = 3'b000;
        case (bar_idx)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= 8'h00;
            g <= 8'h00;
            b <= 8'h00;
        end else if (en) begin
            r <= (active && bar_rgb[2]) ? 8'hFF : 8'h00;
            g <= (active && bar_rgb[1]) ? 8'hFF : 8'h00;
            b <= (active && bar_rgb[0]) ? 8'hFF : 8'h00;
        end
    end
`else
    assign r = 8'h00;
    assign g = 8'h00;
    assign b = 8'h00;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 16x8 raster; colour bars also checked when VTG_TEST_PATTERN_EN is defined.
module tb_video_timing_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic        hsync, vsync, de, line_start, frame_start;
    logic [11:0] x, y;
    logic [7:0]  r, g, b;

    int checks = 0;
    int passes = 0;
    int fs_count;
    int since_fs;
    int ex, ey;
    bit found;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(12)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start),
        .r(r), .g(g), .b(b)
    );

`ifdef VTG_TEST_PATTERN_EN
    logic        hsync16, vsync16, de16, ls16, fs16;
    logic [11:0] x16, y16;
    logic [7:0]  r16, g16, b16;
    int          x2;
    logic [23:0] exp_rgb;

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(12)
    ) u_dut16 (
        .clk(clk), .rst(rst), .en(en),
        .hsync(hsync16), .vsync(vsync16), .de(de16), .x(x16), .y(y16),
        .line_start(ls16), .frame_start(fs16),
        .r(r16), .g(g16), .b(b16)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_hsync"}, {31'd0, hsync}, 32'd1);
        chk({tag, "_vsync"}, {31'd0, vsync}, 32'd1);
        chk({tag, "_de"}, {31'd0, de}, 32'd0);
        chk({tag, "_x"}, {20'd0, x}, 32'd0);
        chk({tag, "_y"}, {20'd0, y}, 32'd0);
        chk({tag, "_ls"}, {31'd0, line_start}, 32'd0);
        chk({tag, "_fs"}, {31'd0, frame_start}, 32'd0);
        chk({tag, "_rgb"}, {8'd0, r, g, b}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        #2 rst = 1'b0;
        #21;
        chk_reset_values("reset");

        @(negedge clk);
        rst = 1'b1;

        // First full frame of the small raster, edge k shows counter state k-1.
        fs_count = 0;
        for (int k = 1; k <= 128; k++) begin
            step();
            ex = (k - 1) % 16;
            ey = (k - 1) / 16;
            if (frame_start) fs_count++;
            chk("frame_x", {20'd0, x}, ex);
            chk("frame_y", {20'd0, y}, ey);
            chk("frame_de", {31'd0, de}, (ex < 8 && ey < 4) ? 1 : 0);
            chk("frame_hsync", {31'd0, hsync}, (ex >= 10 && ex <= 12) ? 0 : 1);
            chk("frame_vsync", {31'd0, vsync}, (ey == 5 || ey == 6) ? 0 : 1);
            chk("frame_ls", {31'd0, line_start}, (ex == 0) ? 1 : 0);
            chk("frame_fs", {31'd0, frame_start}, (ex == 0 && ey == 0) ? 1 : 0);
`ifdef VTG_TEST_PATTERN_EN
            chk("frame_rgb", {8'd0, r, g, b}, (ex < 8 && ey < 4) ? {8'd0, bars[ex]} : 32'd0);
            if (k <= 24) begin
                x2 = k - 1;
                exp_rgb = (x2 < 16) ? bars[x2 / 2] : 24'h000000;
                chk("bar16_x", {20'd0, x16}, x2);
                chk("bar16_rgb", {8'd0, r16, g16, b16}, {8'd0, exp_rgb});
            end
`else
            chk("frame_rgb", {8'd0, r, g, b}, 32'd0);
`endif
        end
        chk("fs_per_frame", fs_count, 1);

        step();
        chk("wrap_fs", {31'd0, frame_start}, 32'd1);
        chk("wrap_x", {20'd0, x}, 32'd0);
        chk("wrap_y", {20'd0, y}, 32'd0);
        since_fs = 0;

        // Freeze at x=3 for five edges.
        for (int i = 0; i < 3; i++) begin
            step();
            since_fs++;
        end
        chk("pre_freeze_x", {20'd0, x}, 32'd3);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            since_fs++;
            chk("freeze_x", {20'd0, x}, 32'd3);
            chk("freeze_de", {31'd0, de}, 32'd1);
            chk("freeze_ls", {31'd0, line_start}, 32'd0);
            chk("freeze_fs", {31'd0, frame_start}, 32'd0);
        end
        en = 1'b1;
        step();
        since_fs++;
        chk("resume_x", {20'd0, x}, 32'd4);

        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            since_fs++;
            if (frame_start) found = 1'b1;
        end
        chk("period_found", {31'd0, found}, 32'd1);
        chk("period_133", since_fs, 133);

        // Freeze right on a frame_start: the strobe must not repeat.
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("hold_fs", {31'd0, frame_start}, 32'd0);
            chk("hold_ls", {31'd0, line_start}, 32'd0);
            chk("hold_x", {20'd0, x}, 32'd0);
            chk("hold_y", {20'd0, y}, 32'd0);
        end
        en = 1'b1;
        step();
        chk("after_hold_x", {20'd0, x}, 32'd1);
        chk("after_hold_fs", {31'd0, frame_start}, 32'd0);

        // Mid-frame asynchronous reset at x=6, y=2.
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (x == 12'd6 && y == 12'd2) found = 1'b1;
        end
        chk("reach_6_2", {31'd0, found}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_reset_values("async_rst");
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("restart_x", {20'd0, x}, 32'd0);
        chk("restart_y", {20'd0, y}, 32'd0);
        chk("restart_de", {31'd0, de}, 32'd1);
        chk("restart_ls", {31'd0, line_start}, 32'd1);
        chk("restart_fs", {31'd0, frame_start}, 32'd1);
        step();
        chk("restart_next_x", {20'd0, x}, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
